// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: instruction-memory handshake plus IF-stage head and control signals
interface instr_fetch_unit_if;
    logic        STALL;
    logic        Redirect;
    logic [31:0] Redirect_Target;
    logic        Instr_Mem_Req;
    logic [31:0] Instr_Mem_Addr;
    logic        Instr_Mem_Ack;
    logic [31:0] Instr_Mem_Data;
    logic [31:0] Instr1_IF;
    logic [31:0] Instr_PC_IF;
    logic [31:0] Instr_PC_Plus4_IF;
    logic        Instr_Valid_IF;
    modport master (
        input  STALL, Redirect, Redirect_Target, Instr_Mem_Ack, Instr_Mem_Data,
        output Instr_Mem_Req, Instr_Mem_Addr, Instr1_IF, Instr_PC_IF, Instr_PC_Plus4_IF, Instr_Valid_IF
    );
    modport slave (
        output STALL, Redirect, Redirect_Target, Instr_Mem_Ack, Instr_Mem_Data,
        input  Instr_Mem_Req, Instr_Mem_Addr, Instr1_IF, Instr_PC_IF, Instr_PC_Plus4_IF, Instr_Valid_IF
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the fetch PC, issues req/ack word fetches and buffers them in a FIFO for IF/ID
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h00400000,
    parameter int          FIFO_DEPTH = 2
) (
    input logic                CLK,
    input logic                RESET,
    instr_fetch_unit_if.master bus
);
    localparam int          AW    = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);
    typedef enum logic {FETCH, DRAIN} state_t;
    state_t        state, state_nxt;
    logic [31:0]   fetch_pc, fetch_pc_nxt, pending_pc, pending_pc_nxt, redirect_pc;
    logic [31:0]   instr_mem [FIFO_DEPTH];
    logic [31:0]   pc_mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count;
    logic          req, xfer, push, pop, valid;

    assign redirect_pc = bus.Redirect_Target & ~32'd3;
    assign valid       = count != '0;
    // Req only falls when the FIFO is full, and count never grows while Req waits, so Req/Addr stay stable
    assign req         = RESET && (state == DRAIN || count < DEPTH);
    assign xfer        = req && bus.Instr_Mem_Ack;
    assign push        = xfer && state == FETCH && !bus.Redirect;
    assign pop         = valid && !bus.STALL && !bus.Redirect;

    always_comb begin
        state_nxt      = state;
        fetch_pc_nxt   = fetch_pc;
        pending_pc_nxt = pending_pc;
        if (state == FETCH) begin
            if (bus.Redirect) begin
                pending_pc_nxt = redirect_pc;
                if (req && !bus.Instr_Mem_Ack) state_nxt = DRAIN;
                else fetch_pc_nxt = redirect_pc;
            end else if (xfer) begin
                fetch_pc_nxt = fetch_pc + 32'd4;
            end
        end else begin
            if (bus.Redirect) pending_pc_nxt = redirect_pc;
            if (xfer) begin
                state_nxt    = FETCH;
                fetch_pc_nxt = pending_pc_nxt;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state      <= FETCH;
            fetch_pc   <= RESET_PC;
            pending_pc <= RESET_PC;
        end else begin
            state      <= state_nxt;
            fetch_pc   <= fetch_pc_nxt;
            pending_pc <= pending_pc_nxt;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET || bus.Redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            instr_mem[wr_ptr] <= bus.Instr_Mem_Data;
            pc_mem[wr_ptr]    <= fetch_pc;
        end
    end

    assign bus.Instr_Mem_Req     = req;
    assign bus.Instr_Mem_Addr    = fetch_pc;
    assign bus.Instr_Valid_IF    = valid;
    assign bus.Instr1_IF         = valid ? instr_mem[rd_ptr] : '0;
    assign bus.Instr_PC_IF       = valid ? pc_mem[rd_ptr] : '0;
    assign bus.Instr_PC_Plus4_IF = valid ? pc_mem[rd_ptr] + 32'd4 : '0;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed stimulus with an expected-PC scoreboard checked by a consumption monitor
module tb_instr_fetch_unit;
    logic CLK = 0;
    logic rst_n, rst_b;
    logic sa, aa, ra, sb, ab;
    logic [31:0] ta;
    int total = 0, passed = 0;
    logic [31:0] exp_a[$], exp_b[$];

    always #5 CLK = ~CLK;

    instr_fetch_unit_if ifa();
    instr_fetch_unit_if ifb();

    instr_fetch_unit dut_a (.CLK(CLK), .RESET(rst_n), .bus(ifa));
    instr_fetch_unit #(.RESET_PC(32'hFFFFFFF8)) dut_b (.CLK(CLK), .RESET(rst_b), .bus(ifb));

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ~a ^ 32'h13572468;
    endfunction

    assign ifa.STALL           = sa;
    assign ifa.Redirect        = ra;
    assign ifa.Redirect_Target = ta;
    assign ifa.Instr_Mem_Ack   = aa;
    assign ifa.Instr_Mem_Data  = mem_word(ifa.Instr_Mem_Addr);
    assign ifb.STALL           = sb;
    assign ifb.Redirect        = 1'b0;
    assign ifb.Redirect_Target = 32'h0;
    assign ifb.Instr_Mem_Ack   = ab;
    assign ifb.Instr_Mem_Data  = mem_word(ifb.Instr_Mem_Addr);

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) $display("FAIL %s: got %h expected %h", name, got, want);
        else passed++;
    endtask

    // every head the downstream register captures must be the next expected PC
    always @(negedge CLK) begin
        if (ifa.Instr_Valid_IF && !sa && !ra) begin
            if (exp_a.size() == 0) chk("a_unexpected_pc", ifa.Instr_PC_IF, 32'hxxxxxxxx);
            else begin
                logic [31:0] p;
                p = exp_a.pop_front();
                chk("a_pc", ifa.Instr_PC_IF, p);
                chk("a_instr", ifa.Instr1_IF, mem_word(p));
                chk("a_plus4", ifa.Instr_PC_Plus4_IF, p + 32'd4);
            end
        end
        if (ifb.Instr_Valid_IF && !sb) begin
            if (exp_b.size() == 0) chk("b_unexpected_pc", ifb.Instr_PC_IF, 32'hxxxxxxxx);
            else begin
                logic [31:0] p;
                p = exp_b.pop_front();
                chk("b_pc", ifb.Instr_PC_IF, p);
                chk("b_instr", ifb.Instr1_IF, mem_word(p));
                chk("b_plus4", ifb.Instr_PC_Plus4_IF, p + 32'd4);
            end
        end
    end

    task automatic cyc(input logic s, input logic a, input logic r, input logic [31:0] t);
        @(posedge CLK); #1;
        sa = s; aa = a; ra = r; ta = t;
        @(negedge CLK);
    endtask

    task automatic cyc_b(input logic s, input logic a);
        @(posedge CLK); #1;
        sb = s; ab = a;
        @(negedge CLK);
    endtask

    task automatic chk_a(input string name, input logic req, input logic [31:0] addr, input logic vld);
        chk({name, "_req"}, 32'(ifa.Instr_Mem_Req), 32'(req));
        chk({name, "_addr"}, ifa.Instr_Mem_Addr, addr);
        chk({name, "_valid"}, 32'(ifa.Instr_Valid_IF), 32'(vld));
    endtask

    initial begin
        rst_n = 0; rst_b = 0; sa = 1; aa = 0; ra = 0; ta = 0; sb = 1; ab = 0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk_a("reset", 1'b0, 32'h00400000, 1'b0);
        chk("reset_instr", ifa.Instr1_IF, 32'h0);
        chk("reset_pc", ifa.Instr_PC_IF, 32'h0);
        chk("reset_plus4", ifa.Instr_PC_Plus4_IF, 32'h0);
        // streaming, then stall fills the FIFO, then release
        exp_a = '{32'h00400000, 32'h00400004, 32'h00400008, 32'h0040000C, 32'h00400010, 32'h00400014};
        @(posedge CLK); #1;
        rst_n = 1; sa = 0; aa = 1;
        @(negedge CLK);
        chk_a("first_req", 1'b1, 32'h00400000, 1'b0);
        repeat (3) cyc(0, 1, 0, 0);
        repeat (5) cyc(1, 1, 0, 0);
        chk_a("stall_full", 1'b0, 32'h00400014, 1'b1);
        chk("stall_head", ifa.Instr_PC_IF, 32'h0040000C);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        // ack withheld: request held stable
        exp_a.push_back(32'h00400018);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0);
            chk_a("wait_ack", 1'b1, 32'h00400018, 1'b0);
            chk("wait_instr", ifa.Instr1_IF, 32'h0);
        end
        cyc(0, 1, 0, 0);
        chk("ack_latency_valid", 32'(ifa.Instr_Valid_IF), 32'h0);
        cyc(0, 0, 0, 0);
        // redirect while a request is pending: drain the stale fetch
        exp_a.push_back(32'h00400100);
        cyc(0, 0, 1, 32'h00400100);
        chk("redir_pending_addr", ifa.Instr_Mem_Addr, 32'h0040001C);
        cyc(0, 0, 0, 0);
        chk_a("drain_hold", 1'b1, 32'h0040001C, 1'b0);
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        chk_a("after_drain", 1'b1, 32'h00400100, 1'b0);
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        // flush buffered entries against a pop, then redirect coincident with ack
        exp_a.push_back(32'h00400200);
        cyc(1, 1, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(0, 1, 1, 32'h00400303);
        chk_a("flush_full", 1'b0, 32'h0040010C, 1'b1);
        cyc(1, 1, 1, 32'h00400203);
        chk_a("redir_ack", 1'b1, 32'h00400300, 1'b0);
        cyc(1, 0, 0, 0);
        chk_a("ack_discarded", 1'b1, 32'h00400200, 1'b0);
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        // second redirect while draining overrides the first target
        cyc(0, 0, 1, 32'h00400500);
        cyc(0, 0, 1, 32'h00400600);
        cyc(0, 1, 0, 0);
        chk_a("drain_stale", 1'b1, 32'h00400204, 1'b0);
        cyc(0, 0, 0, 0);
        chk_a("drain_override", 1'b1, 32'h00400600, 1'b0);
        cyc(0, 0, 1, 32'h0);
        cyc(0, 0, 0, 0);
        chk_a("drain_again", 1'b1, 32'h00400600, 1'b0);
        rst_n = 0;
        #1;
        chk_a("async_reset", 1'b0, 32'h00400000, 1'b0);
        chk("async_reset_instr", ifa.Instr1_IF, 32'h0);
        // PC wrap-around on the second instance
        exp_b = '{32'hFFFFFFF8, 32'hFFFFFFFC, 32'h00000000};
        @(posedge CLK); #1;
        rst_b = 1; sb = 0; ab = 1;
        @(negedge CLK);
        chk("b_first_req", 32'(ifb.Instr_Mem_Req), 32'h1);
        chk("b_first_addr", ifb.Instr_Mem_Addr, 32'hFFFFFFF8);
        cyc_b(0, 1);
        cyc_b(0, 1);
        cyc_b(0, 0);
        chk("b_wrap_addr", ifb.Instr_Mem_Addr, 32'h00000004);
        @(posedge CLK);
        @(negedge CLK);
        chk("a_left_over", 32'(exp_a.size()), 32'h0);
        chk("b_left_over", 32'(exp_b.size()), 32'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
